// File: rtl/vt_vec_fetch_pkg.sv
// rtl/vt_vec_fetch_pkg.sv - shared encodings and constants for the vector fetch master
package vt_vec_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RECOV = 2'd2
  } vf_state_t;

  localparam int RECOV_LEN = 2;
  localparam int TMO_DEF = 16;
  localparam logic [15:0] VEC_ZERO = 16'o000000;

endpackage

// File: rtl/vt_bus_tmo.sv
// rtl/vt_bus_tmo.sv - strobe timeout counter, cleared on load, saturating, terminal-count flag
module vt_bus_tmo #(
  parameter int TMO = 16
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(TMO + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (en && cnt != W'(TMO))
      cnt <= cnt + 1'b1;
  end

  // tc is seen on the cycle whose closing edge would be the TMO-th strobe edge
  assign tc = en && (cnt == W'(TMO - 1));

endmodule

// File: rtl/vt_vec_fetch.sv
// rtl/vt_vec_fetch.sv - wishbone master for vector fetch and unaddressed read cycles
module vt_vec_fetch
  import vt_vec_fetch_pkg::*;
#(
  parameter int TMO = TMO_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_irq_i,
  input  logic        wb_ack_i,
  input  logic [15:0] wb_dat_i,
  output logic        wb_stb_o,
  output logic        wb_una_o,
  output logic        irq_o,
  input  logic        istart_i,
  input  logic        una_req_i,
  output logic [15:0] vec_o,
  output logic        vec_rdy_o,
  output logic        una_o,
  output logic        tmo_o
);

  localparam int RW = (RECOV_LEN > 1) ? $clog2(RECOV_LEN) : 1;

  vf_state_t   state, state_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic        stb_nx, una_tag_nx, rdy_nx, una_done_nx, tmo_nx;
  logic [15:0] vec_nx;
  logic        tmo_load, tmo_tc;

  vt_bus_tmo #(.TMO(TMO)) u_tmo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .load     (tmo_load),
    .en       (state == ST_FETCH),
    .tc       (tmo_tc)
  );

  assign irq_o = wb_irq_i && (state == ST_IDLE);

  always_comb begin
    state_nx    = state;
    rcnt_nx     = rcnt;
    stb_nx      = wb_stb_o;
    una_tag_nx  = wb_una_o;
    vec_nx      = vec_o;
    rdy_nx      = 1'b0;
    una_done_nx = una_o;
    tmo_nx      = 1'b0;
    tmo_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        // unaddressed read takes priority over an interrupt accept
        if (una_req_i || (istart_i && wb_irq_i)) begin
          state_nx   = ST_FETCH;
          stb_nx     = 1'b1;
          una_tag_nx = una_req_i;
          tmo_load   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (wb_ack_i) begin
          vec_nx      = wb_dat_i;
          una_done_nx = wb_una_o;
          rdy_nx      = 1'b1;
          stb_nx      = 1'b0;
          state_nx    = ST_RECOV;
          rcnt_nx     = '0;
        end else if (tmo_tc) begin
          vec_nx   = VEC_ZERO;
          tmo_nx   = 1'b1;
          stb_nx   = 1'b0;
          state_nx = ST_RECOV;
          rcnt_nx  = '0;
        end
      end
      ST_RECOV: begin
        if (rcnt == RW'(RECOV_LEN - 1))
          state_nx = ST_IDLE;
        else
          rcnt_nx = rcnt + 1'b1;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      rcnt      <= '0;
      wb_stb_o  <= 1'b0;
      wb_una_o  <= 1'b0;
      vec_o     <= VEC_ZERO;
      vec_rdy_o <= 1'b0;
      una_o     <= 1'b0;
      tmo_o     <= 1'b0;
    end else begin
      state     <= state_nx;
      rcnt      <= rcnt_nx;
      wb_stb_o  <= stb_nx;
      wb_una_o  <= una_tag_nx;
      vec_o     <= vec_nx;
      vec_rdy_o <= rdy_nx;
      una_o     <= una_done_nx;
      tmo_o     <= tmo_nx;
    end
  end

endmodule
